// File: rtl/instruction_fetch.sv
// instruction_fetch: in-order instruction fetch front end.
// Issues fetch requests to the load/store buffer and tracks the requests that
// are still in flight. Returned words are pushed into a small decoded-instruction
// queue that feeds the decoder. On a redirect the queue is flushed, and responses
// to requests issued before the redirect are counted down and dropped.
// Optional build macro FETCH_PERF_COUNTER_EN adds the fetch_count and
// drop_count performance counters.
//
// Handshakes:
//   request  : new_ins is a one-cycle pulse, and pc_addr is valid in that cycle.
//              No pulse is issued while if_full is high.
//   response : ins_ready is a one-cycle pulse, and ins_value is valid with it.
//              Responses come back in issue order.
//   decode   : the head entry is transferred in any cycle where dec_valid and
//              dec_ready are both high. dec_valid does not wait for dec_ready.
module instruction_fetch #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        if_full,
  input  logic        ins_ready,
  input  logic [31:0] ins_value,
  output logic [31:0] pc_addr,
  output logic        new_ins,
  output logic        dec_valid,
  output logic [31:0] dec_ins,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] drop_count
`endif
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [3:0]       outstanding;
  logic [3:0]       drop;
  logic [CNT_W-1:0] q_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      q_ins [QDEPTH];
  logic [31:0]      q_pc  [QDEPTH];

  logic [3:0]       live;
  logic [4:0]       occupancy;
  logic             issue;
  logic             accept;
  logic             discard;
  logic             pop;

  // Issue, accept, discard and pop decisions, plus the decoder-facing outputs.
  // A request is issued only while queued entries plus live requests leave room,
  // so every live response is guaranteed a queue slot.
  always_comb begin
    live      = outstanding - drop;
    occupancy = 5'(q_count) + {1'b0, live};
    issue     = rst && !redirect && !if_full &&
                (occupancy < 5'(QDEPTH)) && (outstanding < 4'd7);
    accept    = rst && ins_ready && !redirect && (drop == 4'd0);
    discard   = rst && ins_ready && (redirect || (drop != 4'd0));
    pop       = rst && !redirect && (q_count != '0) && dec_ready;
    new_ins   = issue;
    pc_addr   = rst ? fetch_pc : 32'd0;
    dec_valid = rst && (q_count != '0);
    dec_ins   = dec_valid ? q_ins[rd_ptr] : 32'd0;
    dec_pc    = dec_valid ? q_pc[rd_ptr]  : 32'd0;
  end

  // Fetch and response PCs, in-flight bookkeeping, and queue pointers.
  // A redirect turns every request still in flight into a pending drop. A word
  // that returns in the redirect cycle itself is discarded immediately.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= 32'd0;
      resp_pc     <= 32'd0;
      outstanding <= 4'd0;
      drop        <= 4'd0;
      q_count     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding - {3'b000, ins_ready};
      drop        <= outstanding - {3'b000, ins_ready};
      q_count     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + {3'b000, issue} - {3'b000, ins_ready};
      if (ins_ready && (drop != 4'd0)) drop <= drop - 4'd1;
      if (accept) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      q_count <= q_count + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Queue storage. Entries need no reset because q_count qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_ins[wr_ptr] <= ins_value;
      q_pc[wr_ptr]  <= resp_pc;
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  // Counts of accepted and discarded responses. Both counters wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_count <= 32'd0;
      drop_count  <= 32'd0;
    end else begin
      if (accept)  fetch_count <= fetch_count + 32'd1;
      if (discard) drop_count  <= drop_count + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch with QDEPTH=4.
// Inputs are driven 1ns after the rising edge, and outputs are sampled on the
// falling edge. A small memory model returns each word 6 cycles after it was
// requested. Directed scenarios instead drive responses by hand.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_full;
  logic        ins_ready;
  logic [31:0] ins_value;
  logic [31:0] pc_addr;
  logic        new_ins;
  logic        dec_valid;
  logic [31:0] dec_ins;
  logic [31:0] dec_pc;
  logic        dec_ready;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count;
  logic [31:0] drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always #5 clk = ~clk;

  instruction_fetch #(.QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_full(if_full), .ins_ready(ins_ready), .ins_value(ins_value),
    .pc_addr(pc_addr), .new_ins(new_ins), .dec_valid(dec_valid),
    .dec_ins(dec_ins), .dec_pc(dec_pc), .dec_ready(dec_ready)
`ifdef FETCH_PERF_COUNTER_EN
    , .fetch_count(fetch_count), .drop_count(drop_count)
`endif
  );

  // Memory contents: every address holds a distinct word.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; if_full = 1'b0;
    ins_ready = 1'b0; ins_value = 32'd0; dec_ready = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) next_cycle();
    rst = 1'b1;
    cyc = 0;
  endtask

  // Memory model: return the oldest pending request once it is due.
  task automatic mem_drive();
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      ins_ready = 1'b1;
      ins_value = word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      ins_ready = 1'b0;
      ins_value = 32'd0;
    end
  endtask

  task automatic mem_sample();
    if (new_ins) begin
      pend_addr.push_back(pc_addr);
      pend_due.push_back(cyc + 6);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h1234; if_full = 1'b0;
    ins_ready = 1'b1; ins_value = 32'hFFFF; dec_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b0) begin n_fail++; $display("FAIL reset_new_ins got %b want 0", new_ins); end
    n_tests++; if (pc_addr !== 32'd0) begin n_fail++; $display("FAIL reset_pc_addr got %h want 0", pc_addr); end
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
    n_tests++; if (dec_ins !== 32'd0) begin n_fail++; $display("FAIL reset_dec_ins got %h want 0", dec_ins); end
    n_tests++; if (dec_pc !== 32'd0) begin n_fail++; $display("FAIL reset_dec_pc got %h want 0", dec_pc); end
    next_cycle();
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    logic [31:0] exp_dpc;
    int first_dec;
    int n_pops;
    do_reset();
    dec_ready = 1'b1;
    exp_pc = 32'd0; exp_dpc = 32'd0; first_dec = -1; n_pops = 0;
    for (int i = 0; i < 40; i++) begin
      mem_drive();
      @(negedge clk);
      mem_sample();
      if (i == 0) begin
        n_tests++; if (new_ins !== 1'b1) begin n_fail++; $display("FAIL basic_first_issue got %b want 1", new_ins); end
      end
      if (new_ins === 1'b1) begin
        n_tests++; if (pc_addr !== exp_pc) begin n_fail++; $display("FAIL basic_pc_addr got %h want %h", pc_addr, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
      if (dec_valid === 1'b1) begin
        if (first_dec < 0) first_dec = cyc;
        n_tests++; if (dec_pc !== exp_dpc) begin n_fail++; $display("FAIL basic_dec_pc got %h want %h", dec_pc, exp_dpc); end
        n_tests++; if (dec_ins !== word(exp_dpc)) begin n_fail++; $display("FAIL basic_dec_ins got %h want %h", dec_ins, word(exp_dpc)); end
        exp_dpc = exp_dpc + 32'd4;
        n_pops++;
      end
      next_cycle();
    end
    n_tests++; if (first_dec != 7) begin n_fail++; $display("FAIL basic_first_dec_cycle got %0d want 7", first_dec); end
    n_tests++; if (n_pops < 16) begin n_fail++; $display("FAIL basic_pop_count got %0d want >=16", n_pops); end
  endtask

  task automatic test_dec_stall();
    int n_issue;
    do_reset();
    dec_ready = 1'b0;
    n_issue = 0;
    for (int i = 0; i < 20; i++) begin
      mem_drive();
      @(negedge clk);
      mem_sample();
      if (new_ins === 1'b1) n_issue++;
      next_cycle();
    end
    n_tests++; if (n_issue != 4) begin n_fail++; $display("FAIL stall_issue_count got %0d want 4", n_issue); end
    mem_drive();
    dec_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b0) begin n_fail++; $display("FAIL stall_full_new_ins got %b want 0", new_ins); end
    n_tests++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL stall_dec_valid got %b want 1", dec_valid); end
    n_tests++; if (dec_pc !== 32'd0) begin n_fail++; $display("FAIL stall_dec_pc got %h want 0", dec_pc); end
    n_tests++; if (dec_ins !== word(32'd0)) begin n_fail++; $display("FAIL stall_dec_ins got %h want %h", dec_ins, word(32'd0)); end
    next_cycle();
    dec_ready = 1'b0;
    mem_drive();
    @(negedge clk);
    mem_sample();
    n_tests++; if (new_ins !== 1'b1) begin n_fail++; $display("FAIL stall_after_pop_new_ins got %b want 1", new_ins); end
    n_tests++; if (pc_addr !== 32'd16) begin n_fail++; $display("FAIL stall_after_pop_pc got %h want 10", pc_addr); end
    n_tests++; if (dec_pc !== 32'd4) begin n_fail++; $display("FAIL stall_next_head got %h want 4", dec_pc); end
    next_cycle();
  endtask

  task automatic test_if_full();
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if_full = (i >= 2 && i < 12) ? 1'b1 : 1'b0;
      mem_drive();
      @(negedge clk);
      mem_sample();
      if (i >= 2 && i < 12) begin
        n_tests++; if (new_ins !== 1'b0) begin n_fail++; $display("FAIL if_full_new_ins cycle %0d got %b want 0", i, new_ins); end
      end
      if (i == 12) begin
        n_tests++; if (new_ins !== 1'b1) begin n_fail++; $display("FAIL if_full_release_new_ins got %b want 1", new_ins); end
        n_tests++; if (pc_addr !== 32'd8) begin n_fail++; $display("FAIL if_full_release_pc got %h want 8", pc_addr); end
      end
      next_cycle();
    end
    if_full = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (pc_addr !== 32'(i * 4) || new_ins !== 1'b1) begin n_fail++; $display("FAIL redir_issue got %b/%h want 1/%h", new_ins, pc_addr, 32'(i * 4)); end
      next_cycle();
    end
    ins_ready = 1'b1; ins_value = word(32'd0);
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b1 || pc_addr !== 32'd12) begin n_fail++; $display("FAIL redir_issue_with_resp got %b/%h want 1/c", new_ins, pc_addr); end
    next_cycle();
    ins_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100; dec_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b0) begin n_fail++; $display("FAIL redir_cycle_new_ins got %b want 0", new_ins); end
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'd0) begin n_fail++; $display("FAIL redir_pre_head got %b/%h want 1/0", dec_valid, dec_pc); end
    next_cycle();
    redirect = 1'b0;
    ins_ready = 1'b1; ins_value = word(32'd4);
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flushed got %b want 0", dec_valid); end
    n_tests++; if (new_ins !== 1'b1 || pc_addr !== 32'h100) begin n_fail++; $display("FAIL redir_new_pc got %b/%h want 1/100", new_ins, pc_addr); end
    next_cycle();
    if_full = 1'b1;
    ins_value = word(32'd8);
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop2 got %b want 0", dec_valid); end
    next_cycle();
    ins_value = word(32'd12);
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop3 got %b want 0", dec_valid); end
    next_cycle();
    ins_value = word(32'h100);
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop_done got %b want 0", dec_valid); end
    next_cycle();
    ins_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin n_fail++; $display("FAIL redir_head got %b/%h want 1/100", dec_valid, dec_pc); end
    n_tests++; if (dec_ins !== word(32'h100)) begin n_fail++; $display("FAIL redir_head_ins got %h want %h", dec_ins, word(32'h100)); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_empty_after got %b want 0", dec_valid); end
    next_cycle();
    if_full = 1'b0;
  endtask

  task automatic test_redirect_with_resp();
    do_reset();
    dec_ready = 1'b1;
    repeat (2) next_cycle();
    if_full = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h200;
    ins_ready = 1'b1; ins_value = word(32'd0);
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b0) begin n_fail++; $display("FAIL rwr_new_ins got %b want 0", new_ins); end
    next_cycle();
    redirect = 1'b0;
    ins_value = word(32'd4);
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rwr_drop_first got %b want 0", dec_valid); end
    next_cycle();
    ins_ready = 1'b0; if_full = 1'b0;
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rwr_drop_second got %b want 0", dec_valid); end
    n_tests++; if (new_ins !== 1'b1 || pc_addr !== 32'h200) begin n_fail++; $display("FAIL rwr_new_pc got %b/%h want 1/200", new_ins, pc_addr); end
    next_cycle();
    if_full = 1'b1;
    ins_ready = 1'b1; ins_value = word(32'h200);
    next_cycle();
    ins_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200) begin n_fail++; $display("FAIL rwr_head got %b/%h want 1/200", dec_valid, dec_pc); end
    n_tests++; if (dec_ins !== word(32'h200)) begin n_fail++; $display("FAIL rwr_head_ins got %h want %h", dec_ins, word(32'h200)); end
    next_cycle();
    if_full = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    dec_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_new_ins got %b want 0", new_ins); end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b1 || pc_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0 got %b/%h want 1/fffffffc", new_ins, pc_addr); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b1 || pc_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_pc1 got %b/%h want 1/0", new_ins, pc_addr); end
    next_cycle();
    if_full = 1'b1;
    ins_ready = 1'b1; ins_value = word(32'hFFFF_FFFC);
    next_cycle();
    ins_value = word(32'd0);
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_dec0 got %b/%h want 1/fffffffc", dec_valid, dec_pc); end
    next_cycle();
    ins_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'd0) begin n_fail++; $display("FAIL wrap_dec1 got %b/%h want 1/0", dec_valid, dec_pc); end
    n_tests++; if (dec_ins !== word(32'd0)) begin n_fail++; $display("FAIL wrap_dec1_ins got %h want %h", dec_ins, word(32'd0)); end
    next_cycle();
    if_full = 1'b0;
  endtask

  task automatic test_back_to_back_redirect();
    do_reset();
    dec_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h300;
    next_cycle();
    redirect_pc = 32'h400;
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b0) begin n_fail++; $display("FAIL b2b_new_ins got %b want 0", new_ins); end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    n_tests++; if (new_ins !== 1'b1 || pc_addr !== 32'h400) begin n_fail++; $display("FAIL b2b_pc got %b/%h want 1/400", new_ins, pc_addr); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dec_stall();
    test_if_full();
    test_redirect();
    test_redirect_with_resp();
    test_pc_wrap();
    test_back_to_back_redirect();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, meaning decoded-instruction queue depth (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port redirect  input  1  branch/jump mispredict flush request from commit.
REQ-005 SHALL have port redirect_pc  input  32  new fetch address on redirect.
REQ-006 SHALL have port if_full  input  1  load/store-buffer fetch queue full; no request may be issued while high.
REQ-007 SHALL have port ins_ready  input  1  one-cycle pulse: a fetched word is returned, in issue order.
REQ-008 SHALL have port ins_value  input  32  returned instruction word, valid with ins_ready.
REQ-009 SHALL have port pc_addr  output  32  fetch address, valid with new_ins.
REQ-010 SHALL have port new_ins  output  1  one-cycle fetch request pulse.
REQ-011 SHALL have port dec_valid  output  1  queue head valid toward decoder.
REQ-012 SHALL have port dec_ins  output  32  queue head instruction word.
REQ-013 SHALL have port dec_pc  output  32  queue head PC.
REQ-014 SHALL have port dec_ready  input  1  decoder accepts head this cycle.

Function
REQ-015 SHALL hold fetch_pc (next address to request) and resp_pc (PC of next expected response), both 32 bits.
REQ-016 SHALL issue (new_ins=1, pc_addr=fetch_pc, fetch_pc+=4 at next edge) when rst=1, redirect=0, if_full=0, q_count+live<QDEPTH, outstanding<7; else new_ins=0.
REQ-017 SHALL track outstanding (issued, not returned, 4-bit) and drop (responses to discard, 4-bit); live=outstanding-drop.
REQ-018 SHALL on ins_ready: decrement outstanding; if drop>0 decrement drop and discard word; else push {resp_pc, ins_value} and resp_pc+=4.
REQ-019 SHALL never overflow the queue; the REQ-016 condition guarantees space for every live response.
REQ-020 SHALL drive dec_valid=(q_count!=0), dec_ins/dec_pc from head entry; pop when dec_valid&&dec_ready.
REQ-021 SHALL support push and pop in the same cycle (q_count unchanged, pointers both advance, mod QDEPTH wrap).
REQ-022 SHALL on redirect=1: clear queue (q_count=0, pointers 0), fetch_pc=resp_pc=redirect_pc, drop=outstanding (minus 1 if ins_ready same cycle, that word discarded), no issue, no pop that cycle.
REQ-023 SHALL apply a redirect in the cycle after a redirect in full; consecutive redirects keep the last redirect_pc.
REQ-024 SHALL accept an in-flight issue in the same cycle as outstanding decrement (net outstanding unchanged).
REQ-025 SHALL wrap fetch_pc/resp_pc modulo 2^32.

Reset
REQ-026 SHALL while rst=0 at posedge set fetch_pc=0, resp_pc=0, outstanding=0, drop=0, q_count=0, pointers=0.
REQ-027 SHALL while rst=0 drive new_ins=0, pc_addr=0, dec_valid=0, dec_ins=0, dec_pc=0.
REQ-028 SHALL ignore ins_ready, redirect, dec_ready during reset; words returned later for pre-reset requests are not possible (load/store buffer also resets).
REQ-029 SHALL issue the first request (pc_addr=0) in the first cycle after rst rises, if if_full=0.

Configuration
REQ-030 SHALL with FETCH_PERF_COUNTER_EN defined add output fetch_count (32) and drop_count (32): counts of accepted and discarded responses, reset to 0, wrapping.
REQ-031 SHALL without FETCH_PERF_COUNTER_EN omit both ports and counters; all other behaviour identical.

Verification
REQ-032 SHALL test reset release, if_full=0, dec_ready=1, memory returns word after 6 cycles -> new_ins with pc_addr 0,4,8,...; dec_pc 0 with dec_ins = word at 0.
REQ-033 SHALL test dec_ready=0 with QDEPTH=4 -> exactly 4 requests issued, then new_ins stays 0 until a pop.
REQ-034 SHALL test if_full=1 for 10 cycles -> new_ins=0 throughout, fetch_pc unchanged.
REQ-035 SHALL test redirect to 0x100 with 3 outstanding -> next 3 ins_ready discarded, next dec_pc=0x100, queue empty that following cycle.
REQ-036 SHALL test redirect coinciding with ins_ready and 2 outstanding -> that word and one more discarded, drop reaches 0.
REQ-037 SHALL test fetch_pc=0xFFFFFFFC via redirect -> pc_addr sequence 0xFFFFFFFC, 0x00000000.
